// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: request/response and word-memory bus of the data memory access controller
interface dmem_access_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [1:0] req_size;
  logic req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic resp_valid;
  logic [31:0] resp_rdata;
  logic resp_misaligned;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic mem_memwrite;
  logic mem_memread;
  logic [31:0] mem_read_data;
  modport master (
    input req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_write_data, mem_memwrite, mem_memread
  );
  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input req_ready, resp_valid, resp_rdata, resp_misaligned, mem_addr, mem_write_data, mem_memwrite, mem_memread
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: byte/half/word load-store initiator for a word-only memory; DMEM_LOAD_BYPASS_EN answers loads in RD_WAIT
module dmem_access_ctrl #(
  parameter int WORD_ADDR_BITS = 11
) (
  input logic clk,
  input logic reset,
  dmem_access_ctrl_if.master bus
);
  localparam int AW = WORD_ADDR_BITS + 2;
  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, RMW_RD, RMW_MERGE, WR, RESP} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, mwd_q, mwd_d, rdata_q, rdata_d;
  logic [1:0] size_q, size_d;
  logic uns_q, uns_d, write_q, write_d, mis_q, mis_d;
  logic mis_in;
  logic [4:0] sh;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [31:0] ext, mask, merged;
  always_comb begin
    mis_in = bus.req_size == 2'b11 || (bus.req_size == 2'b01 && bus.req_addr[0]) ||
             (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00);
    sh = {addr_q[1:0], 3'b000};
    rbyte = 8'(bus.mem_read_data >> sh);
    rhalf = addr_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
    ext = size_q == 2'b00 ? {{24{!uns_q && rbyte[7]}}, rbyte} :
          size_q == 2'b01 ? {{16{!uns_q && rhalf[15]}}, rhalf} : bus.mem_read_data;
    // halfwords are 2-byte aligned, so the byte shift also places them correctly
    mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    merged = (bus.mem_read_data & ~mask) | ((wdata_q << sh) & mask);
    state_d = state_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    mwd_d = mwd_q;
    rdata_d = rdata_q;
    size_d = size_q;
    uns_d = uns_q;
    write_d = write_q;
    mis_d = mis_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        addr_d = bus.req_addr[AW-1:0];
        wdata_d = bus.req_wdata;
        size_d = bus.req_size;
        uns_d = bus.req_unsigned;
        write_d = bus.req_write;
        mis_d = mis_in;
        if (mis_in) begin
          rdata_d = '0;
`ifdef DMEM_LOAD_BYPASS_EN
          state_d = bus.req_write ? RESP : RD_WAIT;
`else
          state_d = RESP;
`endif
        end else if (bus.req_write && bus.req_size == 2'b10) begin
          mwd_d = bus.req_wdata;
          state_d = WR;
        end else begin
          state_d = bus.req_write ? RMW_RD : RD;
        end
      end
      RD: state_d = RD_WAIT;
      RD_WAIT: begin
        rdata_d = mis_q ? '0 : ext;
`ifdef DMEM_LOAD_BYPASS_EN
        state_d = IDLE;
`else
        state_d = RESP;
`endif
      end
      RMW_RD: state_d = RMW_MERGE;
      RMW_MERGE: begin
        mwd_d = merged;
        state_d = WR;
      end
      WR: begin
        rdata_d = '0;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      mwd_q <= '0;
      rdata_q <= '0;
      size_q <= '0;
      uns_q <= 1'b0;
      write_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      mwd_q <= mwd_d;
      rdata_q <= rdata_d;
      size_q <= size_d;
      uns_q <= uns_d;
      write_q <= write_d;
      mis_q <= mis_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
`ifdef DMEM_LOAD_BYPASS_EN
  assign bus.resp_valid = state_q == RESP || state_q == RD_WAIT;
  assign bus.resp_rdata = state_q == RD_WAIT ? rdata_d : rdata_q;
`else
  assign bus.resp_valid = state_q == RESP;
  assign bus.resp_rdata = rdata_q;
`endif
  assign bus.resp_misaligned = bus.resp_valid && mis_q;
  assign bus.mem_addr = 32'(addr_q[AW-1:2]);
  assign bus.mem_write_data = mwd_q;
  assign bus.mem_memwrite = state_q == WR;
  assign bus.mem_memread = state_q == RD || state_q == RMW_RD;
endmodule
